// File: rtl/haraka_s_sponge_ctrl.sv
// Sponge controller around the Haraka-S permutation core: absorbs 32-byte blocks
// with Haraka-S padding, sequences the core's permutation passes and squeezes digests.
module haraka_s_sponge_ctrl #(
    parameter int unsigned ROUNDS    = 5,
    parameter int unsigned ROUND_LAT = 2,
    parameter int unsigned CNT_W     = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] out_blocks,
    output logic             busy,
    input  logic             msg_valid,
    output logic             msg_ready,
    input  logic [255:0]     msg_data,
    input  logic [5:0]       msg_bytes,
    input  logic             msg_last,
    output logic             dig_valid,
    input  logic             dig_ready,
    output logic [255:0]     dig_data,
    output logic [511:0]     core_in,
    output logic             core_sel,
    input  logic [511:0]     core_out
);
    localparam int unsigned PASS_CYC = ROUNDS * ROUND_LAT;
    localparam int unsigned PC_W     = $clog2(PASS_CYC + 1);

    typedef enum logic [2:0] {IDLE, ABSORB, PERM, PAD, SQUEEZE} fsm_t;

    fsm_t             fsm, fsm_nx;
    logic [511:0]     st, st_nx;
    logic [CNT_W-1:0] sq_cnt, sq_cnt_nx;
    logic [PC_W-1:0]  pc, pc_nx;
    logic             pending_pad, pending_pad_nx;
    logic             pad_done, pad_done_nx;
    int unsigned      nb;
    logic [255:0]     blk;

    // Final partial block: bytes past the message are zeroed, then 0x1F/0x80 pad bytes applied.
    always_comb begin
        nb  = (msg_bytes > 6'd32) ? 32 : 32'(msg_bytes);
        blk = msg_data;
        if (msg_last && nb < 32) begin
            for (int unsigned i = 0; i < 32; i++) begin
                if (i > nb)
                    blk[8*i +: 8] = 8'h00;
                else if (i == nb)
                    blk[8*i +: 8] = 8'h1F;
            end
            blk[255:248] = blk[255:248] ^ 8'h80;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fsm         <= IDLE;
            st          <= '0;
            sq_cnt      <= '0;
            pc          <= '0;
            pending_pad <= 1'b0;
            pad_done    <= 1'b0;
        end else begin
            fsm         <= fsm_nx;
            st          <= st_nx;
            sq_cnt      <= sq_cnt_nx;
            pc          <= pc_nx;
            pending_pad <= pending_pad_nx;
            pad_done    <= pad_done_nx;
        end
    end

    always_comb begin
        fsm_nx         = fsm;
        st_nx          = st;
        sq_cnt_nx      = sq_cnt;
        pc_nx          = pc;
        pending_pad_nx = pending_pad;
        pad_done_nx    = pad_done;
        msg_ready      = 1'b0;
        dig_valid      = 1'b0;
        core_sel       = 1'b0;
        case (fsm)
            IDLE: begin
                if (start) begin
                    st_nx          = '0;
                    sq_cnt_nx      = (out_blocks == '0) ? CNT_W'(1) : out_blocks;
                    pc_nx          = '0;
                    pending_pad_nx = 1'b0;
                    pad_done_nx    = 1'b0;
                    fsm_nx         = ABSORB;
                end
            end
            ABSORB: begin
                msg_ready = !rst;
                if (msg_valid) begin
                    st_nx[255:0] = st[255:0] ^ blk;
                    if (msg_last) begin
                        if (nb < 32) pad_done_nx = 1'b1;
                        else         pending_pad_nx = 1'b1;
                    end
                    pc_nx  = '0;
                    fsm_nx = PERM;
                end
            end
            PAD: begin
                st_nx[255:0]   = st[255:0] ^ {8'h80, 240'h0, 8'h1F};
                pending_pad_nx = 1'b0;
                pad_done_nx    = 1'b1;
                pc_nx          = '0;
                fsm_nx         = PERM;
            end
            PERM: begin
                // Cycle 0 loads the core, middle cycles loop, last cycle captures its output.
                core_sel = (pc != '0) && (pc != PC_W'(PASS_CYC));
                if (pc == PC_W'(PASS_CYC)) begin
                    st_nx = core_out;
                    pc_nx = '0;
                    if (pending_pad)   fsm_nx = PAD;
                    else if (pad_done) fsm_nx = SQUEEZE;
                    else               fsm_nx = ABSORB;
                end else begin
                    pc_nx = pc + PC_W'(1);
                end
            end
            SQUEEZE: begin
                dig_valid = !rst;
                if (dig_ready) begin
                    sq_cnt_nx = sq_cnt - CNT_W'(1);
                    pc_nx     = '0;
                    fsm_nx    = (sq_cnt == CNT_W'(1)) ? IDLE : PERM;
                end
            end
            default: fsm_nx = IDLE;
        endcase
    end

    assign busy     = (fsm != IDLE);
    assign dig_data = st[255:0];
    assign core_in  = st;
endmodule

// File: tb/tb_haraka_s_sponge_ctrl.sv
// Bench for haraka_s_sponge_ctrl: a stand-in core with a fixed mixing function and a
// byte-level sponge model feeding a digest scoreboard.
module tb_haraka_s_sponge_ctrl;
    localparam int PASS_CYC = 10;

    logic         clk = 1'b0;
    logic         rst, start, msg_valid, msg_last, dig_ready;
    logic [3:0]   out_blocks;
    logic [255:0] msg_data;
    logic [5:0]   msg_bytes;
    logic         busy, msg_ready, dig_valid, core_sel;
    logic [255:0] dig_data;
    logic [511:0] core_in, core_out;

    int total = 0;
    int bad   = 0;
    int perms = 0;
    int n     = 0;
    logic [511:0] pass_in;
    logic [255:0] exp_q[$];
    logic [7:0]   mbuf[0:127];

    haraka_s_sponge_ctrl #(.ROUNDS(5), .ROUND_LAT(2), .CNT_W(4)) dut (
        .clk(clk), .rst(rst), .start(start), .out_blocks(out_blocks), .busy(busy),
        .msg_valid(msg_valid), .msg_ready(msg_ready), .msg_data(msg_data),
        .msg_bytes(msg_bytes), .msg_last(msg_last), .dig_valid(dig_valid),
        .dig_ready(dig_ready), .dig_data(dig_data), .core_in(core_in),
        .core_sel(core_sel), .core_out(core_out)
    );

    always #5 clk = ~clk;

    function automatic logic [511:0] perm_f(input logic [511:0] x);
        return {x[444:0], x[511:445]} ^ {x[255:0], x[511:256]} ^ {16{32'h9E3779B9}};
    endfunction

    // Stand-in core: output is only valid after exactly PASS_CYC-1 feedback cycles.
    always @(posedge clk) begin
        if (!core_sel) begin
            if (n == PASS_CYC - 1) perms <= perms + 1;
            pass_in <= core_in;
            n       <= 0;
        end else begin
            n <= n + 1;
        end
    end
    assign core_out = (!core_sel && n == PASS_CYC - 1) ? perm_f(pass_in) : ~pass_in;

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model(input int len, input int nout);
        logic [7:0]   p[$];
        logic [511:0] s;
        for (int i = 0; i < len; i++) p.push_back(mbuf[i]);
        p.push_back(8'h1F);
        while (p.size() % 32 != 0) p.push_back(8'h00);
        p[p.size()-1] = p[p.size()-1] ^ 8'h80;
        s = '0;
        for (int b = 0; b < p.size() / 32; b++) begin
            for (int j = 0; j < 32; j++) s[8*j +: 8] = s[8*j +: 8] ^ p[32*b + j];
            s = perm_f(s);
        end
        for (int k = 0; k < nout; k++) begin
            exp_q.push_back(s[255:0]);
            s = perm_f(s);
        end
    endtask

    task automatic hash(input int len, input int ob, input int stall, input bit sat, input bit poke);
        int nblk, nout, w, p0, padn, rem;
        bit last_b;
        logic [255:0] d, got, exp;
        nblk = (len == 0) ? 1 : (len + 31) / 32;
        nout = (ob == 0) ? 1 : ob;
        padn = (len > 0 && len % 32 == 0) ? 1 : 0;
        model(len, nout);
        p0 = perms;
        out_blocks = 4'(ob);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("busy_after_start", busy, 1);
        if (poke) begin
            out_blocks = 4'd7;
            start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
        end
        for (int b = 0; b < nblk; b++) begin
            last_b = (b == nblk - 1);
            rem = len - 32 * b;
            for (int j = 0; j < 32; j++)
                d[8*j +: 8] = (32*b + j < len) ? mbuf[32*b + j] : 8'($urandom);
            msg_data  = d;
            msg_valid = 1'b1;
            msg_last  = last_b;
            msg_bytes = last_b ? 6'(rem) : 6'($urandom_range(0, 63));
            if (last_b && sat && rem == 32) msg_bytes = 6'd45;
            w = 0;
            while (!msg_ready && w < 100) begin @(posedge clk); #1; w++; end
            chk("msg_ready_wait", msg_ready, 1);
            if (b > 0) chk("ready_gap", w, 11);
            @(posedge clk); #1;
            msg_valid = 1'b0;
            msg_last  = 1'b0;
        end
        for (int k = 0; k < nout; k++) begin
            w = 0;
            while (!dig_valid && w < 100) begin @(posedge clk); #1; w++; end
            chk("dig_valid_wait", dig_valid, 1);
            chk(k == 0 ? "first_dig_gap" : "squeeze_gap", w, (k == 0 && padn == 1) ? 23 : 11);
            got = dig_data;
            for (int s = 0; s < stall; s++) begin
                if (poke && s == 1) start = 1'b1;
                @(posedge clk); #1;
                start = 1'b0;
                chk("dig_stable", dig_data, got);
                chk("dig_held", dig_valid, 1);
            end
            dig_ready = 1'b1;
            @(posedge clk); #1;
            dig_ready = 1'b0;
            exp = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
            chk("digest", got, exp);
        end
        chk("busy_drop", busy, 0);
        chk("perm_count", perms - p0, nblk + padn + nout - 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; start = 1'b0; msg_valid = 1'b0; msg_last = 1'b0; dig_ready = 1'b0;
        out_blocks = '0; msg_data = '0; msg_bytes = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_msg_ready", msg_ready, 0);
        chk("rst_dig_valid", dig_valid, 0);
        chk("rst_core_sel", core_sel, 0);
        chk("rst_dig_data", dig_data, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        // empty message
        hash(0, 1, 0, 1'b0, 1'b0);
        // one full block 0x00..0x1F, padding goes to a separate block
        for (int i = 0; i < 32; i++) mbuf[i] = 8'(i);
        hash(32, 1, 0, 1'b0, 1'b0);
        // three blocks, last one 31 bytes
        for (int i = 0; i < 95; i++) mbuf[i] = 8'($urandom);
        hash(95, 1, 0, 1'b0, 1'b0);
        // multi-block squeeze with a stalled consumer
        for (int i = 0; i < 40; i++) mbuf[i] = 8'(i * 7 + 3);
        hash(40, 3, 5, 1'b0, 1'b0);

        // abort mid-permutation, then hash "abc"
        out_blocks = 4'd1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        msg_data = {8{32'hDEADBEEF}}; msg_valid = 1'b1; msg_last = 1'b0; msg_bytes = 6'd0;
        @(posedge clk); #1;
        msg_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        chk("abort_busy", busy, 0);
        chk("abort_msg_ready", msg_ready, 0);
        chk("abort_dig_valid", dig_valid, 0);
        chk("abort_core_sel", core_sel, 0);
        chk("abort_dig_data", dig_data, 0);
        rst = 1'b0;
        @(posedge clk); #1;
        mbuf[0] = 8'h61; mbuf[1] = 8'h62; mbuf[2] = 8'h63;
        hash(3, 1, 0, 1'b0, 1'b0);

        // out_blocks=0, saturating msg_bytes, start pulses mid-hash
        for (int i = 0; i < 32; i++) mbuf[i] = 8'(255 - i);
        hash(32, 0, 3, 1'b1, 1'b1);

        chk("scoreboard_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
